// File: rtl/sw_stream_dispatcher_pkg.sv
// Shared constants for the stream dispatcher: FSM encoding, header field
// offsets and default parameter values.
package sw_stream_dispatcher_pkg;

  localparam int DEF_DATA_W    = 128;
  localparam int DEF_NUM_LANES = 4;
  localparam int DEF_LEN_W     = 16;

  // Header layout: len at the bottom, 2-bit lane index directly above it.
  localparam int LEN_LSB  = 0;
  localparam int LANE_LSB = DEF_LEN_W;
  localparam int LANE_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  // Lane field offset for a given length width (it always sits right above len).
  function automatic int lane_lsb(input int len_w);
    return LANE_LSB - DEF_LEN_W + len_w;
  endfunction

endpackage

// File: rtl/sw_dispatch_skid_buf.sv
// Two-entry input buffer in front of the FIFO. Tracks words still in flight
// from the FIFO (read issued last cycle, data on fifo_dout_i this cycle) so the
// buffer can never be oversubscribed while still streaming one word per cycle.
module sw_dispatch_skid_buf
  import sw_stream_dispatcher_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_dout_i,
  input  logic              pop_i,
  output logic              fifo_rd_en_o,
  output logic              head_valid_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              next_nonempty_o
);

  logic [1:0]        occ_q, occ_d;
  logic              inflight_q;
  logic              run_q;
  logic [DATA_W-1:0] data0_q, data0_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic              pop;
  logic [1:0]        slot;
  logic [2:0]        level;

  // A pop is only honoured when the head actually holds a word.
  assign pop   = pop_i & (occ_q != 2'd0);
  // Slot that an arriving word lands in once this cycle's pop has shifted.
  assign slot  = occ_q - {1'b0, pop};
  // Words that will be held next cycle, counting the one currently in flight.
  assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

  // run_q keeps reads off until the first clock edge after reset release.
  assign fifo_rd_en_o    = run_q & ~fifo_empty_i & (level < 3'd2);
  assign next_nonempty_o = (level != 3'd0);
  assign head_valid_o    = (occ_q != 2'd0);
  assign head_data_o     = data0_q;

  // Next buffer contents: shift on pop, then write the landing word behind.
  always_comb begin
    data0_d = data0_q;
    data1_d = data1_q;
    occ_d   = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    if (pop) begin
      data0_d = data1_q;
    end else begin
      data0_d = data0_q;
    end
    case ({inflight_q, slot})
      3'b100:  data0_d = fifo_dout_i;
      3'b101:  data1_d = fifo_dout_i;
      default: ;
    endcase
  end

  // Buffer storage, occupancy and in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      run_q      <= 1'b0;
      data0_q    <= '0;
      data1_q    <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en_o;
      run_q      <= 1'b1;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
    end
  end

endmodule

// File: rtl/sw_stream_dispatcher.sv
// Job dispatcher: pulls header + payload words from the input buffer and
// steers each payload word to the lane named in the job header.
module sw_stream_dispatcher
  import sw_stream_dispatcher_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int LEN_W     = DEF_LEN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 fifo_empty,
  input  logic [DATA_W-1:0]    fifo_dout,
  output logic                 fifo_rd_en,
  output logic [NUM_LANES-1:0] lane_valid,
  input  logic [NUM_LANES-1:0] lane_ready,
  output logic [DATA_W-1:0]    lane_data,
  output logic                 lane_last,
  output logic                 busy,
  output logic [31:0]          job_count
);

  localparam int                   HDR_LANE_LSB = lane_lsb(LEN_W);
  localparam logic [LEN_W-1:0]     LEN_ONE      = LEN_W'(1);
  localparam logic [NUM_LANES-1:0] LANE_ONE     = NUM_LANES'(1);

  state_e            state_q;
  logic [LANE_W-1:0] lane_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [31:0]       job_count_q;

  logic              head_valid;
  logic [DATA_W-1:0] head_data;
  logic              next_nonempty;
  logic              payload_valid;
  logic              hs;
  logic              pop;
  logic [LEN_W-1:0]  hdr_len;
  logic [LANE_W-1:0] hdr_lane;

  sw_dispatch_skid_buf #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_empty_i   (fifo_empty),
    .fifo_dout_i    (fifo_dout),
    .pop_i          (pop),
    .fifo_rd_en_o   (fifo_rd_en),
    .head_valid_o   (head_valid),
    .head_data_o    (head_data),
    .next_nonempty_o(next_nonempty)
  );

  assign hdr_len  = head_data[LEN_LSB +: LEN_W];
  assign hdr_lane = head_data[HDR_LANE_LSB +: LANE_W];

  // Only the selected lane's ready matters; the header is always popped in HDR.
  assign payload_valid = (state_q == ST_PAYLOAD) & head_valid;
  assign hs            = payload_valid & lane_ready[lane_q];
  assign pop           = hs | ((state_q == ST_HDR) & head_valid);

  assign lane_data = head_data;
  assign lane_last = payload_valid & (remaining_q == LEN_ONE);
  assign busy      = (state_q != ST_IDLE);
  assign job_count = job_count_q;

  // One-hot valid on the job's lane whenever a payload word is at the head.
  always_comb begin
    lane_valid = '0;
    if (payload_valid) begin
      lane_valid = LANE_ONE << lane_q;
    end else begin
      lane_valid = '0;
    end
  end

  // Job sequencing. On the final handshake, jump straight to HDR when the next
  // header is already buffered or landing, so jobs run with a single gap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lane_q      <= '0;
      remaining_q <= '0;
      job_count_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en && head_valid) begin
            state_q <= ST_HDR;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_HDR: begin
          if (head_valid) begin
            lane_q      <= hdr_lane;
            remaining_q <= hdr_len;
            if (hdr_len == '0) begin
              job_count_q <= job_count_q + 32'd1;
              state_q     <= ST_IDLE;
            end else begin
              state_q     <= ST_PAYLOAD;
            end
          end else begin
            state_q <= ST_HDR;
          end
        end
        ST_PAYLOAD: begin
          if (hs) begin
            remaining_q <= remaining_q - LEN_ONE;
            if (remaining_q == LEN_ONE) begin
              job_count_q <= job_count_q + 32'd1;
              state_q     <= (en && next_nonempty) ? ST_HDR : ST_IDLE;
            end else begin
              state_q <= ST_PAYLOAD;
            end
          end else begin
            state_q <= ST_PAYLOAD;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_stream_dispatcher.sv
// Directed bench for sw_stream_dispatcher. A simple synchronous FIFO model
// (write and read on the same clock) feeds the dispatcher; a job-level model
// predicts every payload word (lane, data, last) and is compared each cycle.
module tb_sw_stream_dispatcher;

  localparam int DW = 128;
  localparam int NL = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic [NL-1:0] lane_valid;
  logic [NL-1:0] lane_ready;
  logic [DW-1:0] lane_data;
  logic          lane_last;
  logic          busy;
  logic [31:0]   job_count;
  logic          wr_en;
  logic [DW-1:0] wr_data;

  typedef struct {
    logic [1:0]    lane;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] fq[$];
  logic [DW-1:0] dlv_data[$];
  int            dlv_cyc[$];
  logic          dlv_last[$];
  logic [NL-1:0] dlv_lv[$];
  int            busy_cycles = 0;
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  sw_stream_dispatcher #(
    .DATA_W(DW),
    .NUM_LANES(NL),
    .LEN_W(LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .lane_valid(lane_valid),
    .lane_ready(lane_ready),
    .lane_data (lane_data),
    .lane_last (lane_last),
    .busy      (busy),
    .job_count (job_count)
  );

  // Synchronous FIFO model: read data appears the cycle after fifo_rd_en.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      fifo_dout  <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en && fq.size() != 0) fifo_dout <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic chki(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Per-cycle comparison against the job model.
  initial begin
    exp_t ce;
    logic hs, hdr_pop, prev_pending, prev_busy, prev_last_hs;
    int   held;
    prev_pending = 1'b0; prev_busy = 1'b0; prev_last_hs = 1'b0; held = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_pending = 1'b0; prev_busy = 1'b0; prev_last_hs = 1'b0; held = 0;
      end else begin
        hs = |(lane_valid & lane_ready);
        if (busy) busy_cycles++;
        if (lane_valid != '0) begin
          if (exp_q.size() == 0) begin
            chki("spurious_valid", int'(lane_valid), 0);
          end else begin
            ce = exp_q[0];
            chki("lane_onehot", int'(lane_valid), int'(4'b0001 << ce.lane));
            chk("lane_data", lane_data, ce.data);
            chki("lane_last", int'(lane_last), int'(ce.last));
          end
          if (hs) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            dlv_data.push_back(lane_data);
            dlv_cyc.push_back(cyc);
            dlv_last.push_back(lane_last);
            dlv_lv.push_back(lane_valid);
          end
        end else begin
          chki("last_without_valid", int'(lane_last), 0);
        end
        if (prev_pending) chki("hold_valid", int'(lane_valid != '0), 1);
        hdr_pop = busy && (!prev_busy || prev_last_hs);
        held = held + int'(fifo_rd_en && !fifo_empty) - int'(hs) - int'(hdr_pop);
        chki("buf_bound", int'(held >= 0 && held <= 2), 1);
        chki("read_when_empty", int'(fifo_rd_en && fifo_empty), 0);
        prev_pending = (lane_valid != '0) && !hs;
        prev_busy    = busy;
        prev_last_hs = hs && lane_last;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    tick();
    wr_en   = 1'b0;
  endtask

  function automatic logic [DW-1:0] mk_hdr(input logic [1:0] ln, input logic [LW-1:0] len);
    logic [DW-1:0] h;
    h = {8'hC3, {(DW-8){1'b0}}};
    h[LW+2] = 1'b1;
    h[LW-1:0] = len;
    h[LW+1:LW] = ln;
    return h;
  endfunction

  task automatic send_job(input logic [1:0] ln, input int len, input logic [DW-1:0] base);
    exp_t je;
    push_word(mk_hdr(ln, LW'(len)));
    for (int i = 0; i < len; i++) begin
      je.lane = ln;
      je.data = base + DW'(i);
      je.last = (i == len - 1);
      exp_q.push_back(je);
      push_word(je.data);
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      tick();
      k++;
    end
    chki(name, int'(exp_q.size() == 0 && !busy), 1);
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, k;
    en = 1'b0; lane_ready = '0; wr_en = 1'b0; wr_data = '0; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chki("rst_lane_valid", int'(lane_valid), 0);
    chki("rst_lane_last", int'(lane_last), 0);
    chk("rst_lane_data", lane_data, '0);
    chki("rst_busy", int'(busy), 0);
    chki("rst_job_count", int'(job_count), 0);
    chki("rst_rd_en", int'(fifo_rd_en), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Job lane 2, len 3, A/B/C, all lanes ready.
    lane_ready = 4'hF;
    b = dlv_data.size();
    send_job(2'd2, 3, 'hA);
    repeat (4) tick();
    en = 1'b1;
    wait_done(100, "t1_done");
    chki("t1_count", dlv_data.size(), b + 3);
    if (dlv_data.size() >= b + 3) begin
      chk("t1_data0", dlv_data[b], 'hA);
      chk("t1_data1", dlv_data[b+1], 'hB);
      chk("t1_data2", dlv_data[b+2], 'hC);
      chki("t1_lanes", int'(dlv_lv[b]), 4);
      chki("t1_last_ab", int'(dlv_last[b] | dlv_last[b+1]), 0);
      chki("t1_last_c", int'(dlv_last[b+2]), 1);
      chki("t1_consecutive", dlv_cyc[b+2] - dlv_cyc[b], 2);
    end
    chki("t1_job_count", int'(job_count), 1);

    // Zero-length job on lane 1.
    b = dlv_data.size();
    k = busy_cycles;
    push_word(mk_hdr(2'd1, 16'd0));
    repeat (10) tick();
    chki("t2_busy_cycles", busy_cycles - k, 1);
    chki("t2_no_payload", dlv_data.size(), b);
    chki("t2_job_count", int'(job_count), 2);

    // Lane 0 len 4 with toggling ready; other lanes' ready held high.
    lane_ready = 4'b1110;
    b = dlv_data.size();
    send_job(2'd0, 4, 'h100);
    for (int t = 0; t < 60 && dlv_data.size() < b + 4; t++) begin
      lane_ready = {3'b111, (t % 2 == 0) ? 1'b1 : 1'b0};
      tick();
    end
    lane_ready = 4'hF;
    wait_done(50, "t3_done");
    chki("t3_count", dlv_data.size(), b + 4);
    if (dlv_data.size() >= b + 4) begin
      for (int i = 0; i < 4; i++) chk("t3_order", dlv_data[b+i], 'h100 + DW'(i));
    end
    chki("t3_job_count", int'(job_count), 3);

    // Back-to-back jobs: lane 3 len 2, then lane 1 len 2.
    b = dlv_data.size();
    send_job(2'd3, 2, 'h200);
    send_job(2'd1, 2, 'h300);
    wait_done(100, "t4_done");
    chki("t4_count", dlv_data.size(), b + 4);
    if (dlv_data.size() >= b + 4) begin
      chki("t4_job1_last", int'(dlv_last[b+1]), 1);
      chk("t4_job2_first", dlv_data[b+2], 'h300);
      chki("t4_job2_lane", int'(dlv_lv[b+2]), 2);
      chki("t4_gap", dlv_cyc[b+2] - dlv_cyc[b+1], 2);
    end
    chki("t4_job_count", int'(job_count), 5);

    // en dropped while job 1 runs; job 2 must wait for en.
    lane_ready = '0;
    b = dlv_data.size();
    send_job(2'd0, 3, 'h400);
    k = 0;
    while (!busy && k < 50) begin
      tick();
      k++;
    end
    chki("t5_start", int'(busy), 1);
    en = 1'b0;
    send_job(2'd2, 2, 'h500);
    lane_ready = 4'hF;
    repeat (20) tick();
    chki("t5_job1_words", dlv_data.size(), b + 3);
    chki("t5_job2_held", int'(busy), 0);
    chki("t5_count1", int'(job_count), 6);
    en = 1'b1;
    wait_done(100, "t5_done");
    chki("t5_total_words", dlv_data.size(), b + 5);
    if (dlv_data.size() >= b + 5) begin
      chk("t5_job2_w0", dlv_data[b+3], 'h500);
      chk("t5_job2_w1", dlv_data[b+4], 'h501);
    end
    chki("t5_job_count", int'(job_count), 7);

    // Reset in the middle of a 5-word job after 2 words.
    lane_ready = '0;
    send_job(2'd1, 5, 'h600);
    repeat (4) tick();
    b = dlv_data.size();
    lane_ready = 4'hF;
    tick();
    tick();
    lane_ready = '0;
    chki("t6_two_words", dlv_data.size(), b + 2);
    #1 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chki("t6_lane_valid", int'(lane_valid), 0);
    chki("t6_lane_last", int'(lane_last), 0);
    chk("t6_lane_data", lane_data, '0);
    chki("t6_busy", int'(busy), 0);
    chki("t6_job_count", int'(job_count), 0);
    chki("t6_rd_en", int'(fifo_rd_en), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    chki("t6_idle_after", int'(busy), 0);
    chki("t6_no_valid_after", int'(lane_valid), 0);
    chki("t6_count_after", int'(job_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
